// File: rtl/qam_symbol_mapper.sv
// qam_symbol_mapper: byte stream to Gray-coded QPSK/16-QAM I/Q levels, one symbol per baud tick
// Optional feature macro: QAM_SCRAMBLE_EN adds an x^7+x^4+1 additive scrambler applied at byte pop.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   mod_type                 0 = QPSK, 1 = 16-QAM (latched per byte or idle tick)
//   baud_rate                1200 << baud_rate Bd (latched per byte or idle tick)
//   s_data, s_valid, s_ready byte input stream, MSB sent first
//   sym_i, sym_q             signed I/Q levels, held between symbols
//   sym_valid                one-cycle strobe per baud period (data or idle)
//   sym_idle                 current symbol is a zero symbol
//   underrun                 pulse on the first idle symbol after data
module qam_symbol_mapper #(
   parameter int CLK_HZ     = 11_059_200,
   parameter int AMP_W      = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mod_type,
   input  logic [1:0]              baud_rate,
   input  logic [7:0]              s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic signed [AMP_W-1:0] sym_i,
   output logic signed [AMP_W-1:0] sym_q,
   output logic                    sym_valid,
   output logic                    sym_idle,
   output logic                    underrun
);
   localparam int CW = $clog2(CLK_HZ / 1200);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LV = (2 ** (AMP_W - 1) - 1) / 3;
   localparam logic [CW-1:0] D0 = CW'(CLK_HZ / 1200 - 1);
   localparam logic [CW-1:0] D1 = CW'(CLK_HZ / 2400 - 1);
   localparam logic [CW-1:0] D2 = CW'(CLK_HZ / 4800 - 1);
   localparam logic [CW-1:0] D3 = CW'(CLK_HZ / 9600 - 1);
   localparam logic signed [AMP_W-1:0] P1 = AMP_W'(LV);
   localparam logic signed [AMP_W-1:0] P2 = AMP_W'(2 * LV);
   localparam logic signed [AMP_W-1:0] P3 = AMP_W'(3 * LV);
   localparam logic signed [AMP_W-1:0] N1 = AMP_W'(-LV);
   localparam logic signed [AMP_W-1:0] N2 = AMP_W'(-2 * LV);
   localparam logic signed [AMP_W-1:0] N3 = AMP_W'(-3 * LV);

   logic [CW-1:0]           div_cnt, div_last;
   logic [1:0]              baud_lat, rem;
   logic                    mod_lat, tick, busy, wr, pop, idle_t, m, had_data;
   logic [7:0]              mem [FIFO_DEPTH];
   logic [AW-1:0]           wp, rp;
   logic [AW:0]             fcnt;
   logic [7:0]              head, sh, sym_bits;
   logic signed [AMP_W-1:0] lvl_i, lvl_q;

   // Divisor constants are precomputed so no run-time divider is built.
   assign div_last = baud_lat[1] ? (baud_lat[0] ? D3 : D2) : (baud_lat[0] ? D1 : D0);
   assign tick     = div_cnt == div_last;
   assign s_ready  = fcnt != (AW+1)'(FIFO_DEPTH);
   assign wr       = s_valid && s_ready;
   assign busy     = rem != 2'd0;
   assign pop      = tick && !busy && fcnt != '0;
   assign idle_t   = tick && !busy && fcnt == '0;

`ifdef QAM_SCRAMBLE_EN
   logic [6:0] lfsr, lfsr_nx;
   // Eight LFSR steps unrolled; the byte's MSB consumes the first keystream bit.
   always_comb begin
      lfsr_nx = lfsr;
      head    = mem[rp];
      for (int b = 7; b >= 0; b--) begin
         head[b] = head[b] ^ lfsr_nx[6] ^ lfsr_nx[3];
         lfsr_nx = {lfsr_nx[5:0], lfsr_nx[6] ^ lfsr_nx[3]};
      end
   end
   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= 7'h7F;
      else if (pop)
         lfsr <= lfsr_nx;
   end
`else
   assign head = mem[rp];
`endif

   // At a byte boundary the first symbol comes straight from the popped byte
   // using the live mod_type; mid-byte symbols use the latched mode.
   assign m        = busy ? mod_lat : mod_type;
   assign sym_bits = busy ? sh : head;

   // Gray levels: MSB selects the sign, LSB selects the inner ring.
   function automatic logic signed [AMP_W-1:0] gray(input logic [1:0] b);
      return b[0] ? (b[1] ? P1 : N1) : (b[1] ? P3 : N3);
   endfunction

   assign lvl_i = m ? gray(sym_bits[7:6]) : (sym_bits[7] ? P2 : N2);
   assign lvl_q = m ? gray(sym_bits[5:4]) : (sym_bits[6] ? P2 : N2);

   always_ff @(posedge clk) begin
      if (wr)
         mem[wp] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         baud_lat  <= '0;
         mod_lat   <= 1'b0;
         wp        <= '0;
         rp        <= '0;
         fcnt      <= '0;
         sh        <= '0;
         rem       <= '0;
         had_data  <= 1'b0;
         sym_i     <= '0;
         sym_q     <= '0;
         sym_valid <= 1'b0;
         sym_idle  <= 1'b1;
         underrun  <= 1'b0;
      end else begin
         div_cnt   <= tick ? '0 : div_cnt + 1'b1;
         wp        <= wr ? wp + 1'b1 : wp;
         rp        <= pop ? rp + 1'b1 : rp;
         fcnt      <= fcnt + (AW+1)'(wr) - (AW+1)'(pop);
         sym_valid <= tick;
         underrun  <= idle_t && had_data;
         if (tick) begin
            sym_i    <= idle_t ? '0 : lvl_i;
            sym_q    <= idle_t ? '0 : lvl_q;
            sym_idle <= idle_t;
            had_data <= !idle_t;
            sh       <= m ? sym_bits << 4 : sym_bits << 2;
            rem      <= busy ? rem - 1'b1 : (pop ? (mod_type ? 2'd1 : 2'd3) : 2'd0);
         end
         if (tick && !busy) begin
            mod_lat  <= mod_type;
            baud_lat <= baud_rate;
         end
      end
   end
endmodule

// File: tb/tb_qam_symbol_mapper.sv
// tb_qam_symbol_mapper: self-checking bench for qam_symbol_mapper (table vectors, directed sequences, scoreboard)
module tb_qam_symbol_mapper;
   logic              clk = 1'b0, rst = 1'b1, mod_type = 1'b0, s_valid = 1'b0;
   logic [1:0]        baud_rate = 2'd0;
   logic [7:0]        s_data = 8'h00;
   logic              s_ready, sym_valid, sym_idle, underrun;
   logic signed [11:0] sym_i, sym_q;
   int                checks = 0, errors = 0, cyc = 0, last_c = 0;
   bit                prev_data = 1'b0;
   logic [6:0]        lfsr_m = 7'h7F;

   typedef struct { int i; int q; bit idle; bit un; int c; } ev_t;
   typedef struct { int i; int q; } sym_t;
   typedef struct { logic [7:0] b; bit m; int n; int ei[4]; int eq[4]; } vec_t;
   localparam int GRAY [4] = '{-2046, -682, 2046, 682};

   ev_t  evq[$];
   sym_t exp_q[$];

   qam_symbol_mapper dut (
      .clk(clk), .rst(rst), .mod_type(mod_type), .baud_rate(baud_rate),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid),
      .sym_idle(sym_idle), .underrun(underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (sym_valid) evq.push_back('{int'(sym_i), int'(sym_q), sym_idle, underrun, cyc});

   task automatic chk(input string name, input integer act, input integer exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] keystream();
`ifdef QAM_SCRAMBLE_EN
      logic [7:0] k;
      bit fb;
      for (int n = 7; n >= 0; n--) begin
         fb = lfsr_m[6] ^ lfsr_m[3];
         k[n] = fb;
         lfsr_m = {lfsr_m[5:0], fb};
      end
      return k;
`else
      return 8'h00;
`endif
   endfunction

   function automatic void push_syms(input logic [7:0] b, input bit m);
      if (m)
         for (int k = 0; k < 2; k++) exp_q.push_back('{GRAY[b[7-4*k -: 2]], GRAY[b[5-4*k -: 2]]});
      else
         for (int k = 0; k < 4; k++) exp_q.push_back('{b[7-2*k] ? 1364 : -1364, b[6-2*k] ? 1364 : -1364});
   endfunction

   // Bytes are pre-whitened with the model keystream so the mapped payload equals b.
   task automatic send(input logic [7:0] b, input int budget, output int acc_c);
      logic [7:0] k;
      k = keystream();
      s_data = b ^ k;
      s_valid = 1'b1;
      acc_c = -1;
      for (int n = 0; n < budget && acc_c < 0; n++) begin
         if (s_ready) begin
            acc_c = cyc;
            push_syms(b, mod_type);
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk($sformatf("send_%02h_accepted", b), acc_c >= 0, 1);
   endtask

   task automatic next_ev(input int budget, output ev_t e);
      int n = 0;
      while (evq.size() == 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (evq.size() == 0) begin
         e = '{9999, 9999, 1'b0, 1'b0, cyc};
         checks++;
         errors++;
         $display("FAIL ev_timeout: no sym_valid within %0d cycles", budget);
      end else
         e = evq.pop_front();
   endtask

   task automatic expect_sym(input string name, input int ei, input int eq, input bit eidle, input int gap);
      ev_t e;
      bit  eu;
      eu = eidle && prev_data;
      prev_data = !eidle;
      next_ev(gap + 20, e);
      chk({name, "_i"}, e.i, ei);
      chk({name, "_q"}, e.q, eq);
      chk({name, "_idle"}, e.idle, eidle);
      chk({name, "_underrun"}, e.un, eu);
      chk({name, "_gap"}, e.c - last_c, gap);
      last_c = e.c;
   endtask

   task automatic drain(input string name, input int gap);
      sym_t s;
      while (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         expect_sym(name, s.i, s.q, 1'b0, gap);
      end
      expect_sym({name, "_end"}, 0, 0, 1'b1, gap);
   endtask

   initial begin
      vec_t tbl [3];
      sym_t s;
      int   acc;
      tbl[0] = '{8'hB4, 1'b0, 4, '{1364, 1364, -1364, -1364}, '{-1364, 1364, 1364, -1364}};
      tbl[1] = '{8'h2D, 1'b1, 2, '{-2046, 682, 0, 0}, '{2046, -682, 0, 0}};
      tbl[2] = '{8'h9C, 1'b1, 2, '{2046, 682, 0, 0}, '{-682, -2046, 0, 0}};

      repeat (5) @(negedge clk);
      chk("rst_sym_i", sym_i, 0);
      chk("rst_sym_q", sym_q, 0);
      chk("rst_sym_idle", sym_idle, 1);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_sym_valid", sym_valid, 0);
      chk("rst_underrun", underrun, 0);
      rst = 1'b0;
      last_c = cyc;

      // QPSK byte at 1200 Bd; switch to 9600 Bd during its second symbol
      send(8'h1B, 4, acc);
      for (int k = 0; k < 4; k++) begin
         s = exp_q.pop_front();
         expect_sym($sformatf("cfg_a%0d", k), s.i, s.q, 1'b0, 9216);
         if (k == 1) begin
            baud_rate = 2'd3;
            mod_type = 1'b1;
            send(8'h2D, 4, acc);
         end
      end
      s = exp_q.pop_front();
      expect_sym("cfg_b0", s.i, s.q, 1'b0, 9216);
      s = exp_q.pop_front();
      expect_sym("cfg_b1", s.i, s.q, 1'b0, 1152);
      expect_sym("cfg_end", 0, 0, 1'b1, 1152);

      for (int t = 0; t < 3; t++) begin
         mod_type = tbl[t].m;
         send(tbl[t].b, 4, acc);
         exp_q.delete();
         for (int k = 0; k < tbl[t].n; k++)
            expect_sym($sformatf("tbl%0d_s%0d", t, k), tbl[t].ei[k], tbl[t].eq[k], 1'b0, 1152);
         expect_sym($sformatf("tbl%0d_end", t), 0, 0, 1'b1, 1152);
      end

      // Backpressure: four bytes fill the FIFO, the fifth waits for the first pop
      mod_type = 1'b1;
      for (int k = 1; k <= 4; k++) send(8'(k), 4, acc);
      chk("bp_ready_low", s_ready, 0);
      send(8'h05, 1300, acc);
      chk("bp_accept_cycle", acc, last_c + 1152);
      drain("bp", 1152);

      for (int r = 0; r < 2; r++) begin
         mod_type = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 1000)) @(negedge clk);
         send(8'($urandom), 4, acc);
         drain($sformatf("rnd%0d", r), 1152);
      end

      // Reset between symbols 2 and 3 with another byte still queued
      mod_type = 1'b0;
      send(8'hB4, 4, acc);
      send(8'h55, 4, acc);
      s = exp_q.pop_front();
      expect_sym("mid_s0", s.i, s.q, 1'b0, 1152);
      s = exp_q.pop_front();
      expect_sym("mid_s1", s.i, s.q, 1'b0, 1152);
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_sym_i", sym_i, 0);
      chk("mid_rst_sym_q", sym_q, 0);
      chk("mid_rst_sym_idle", sym_idle, 1);
      chk("mid_rst_s_ready", s_ready, 1);
      chk("mid_rst_sym_valid", sym_valid, 0);
      chk("mid_rst_underrun", underrun, 0);
      rst = 1'b0;
      exp_q.delete();
      lfsr_m = 7'h7F;
      prev_data = 1'b0;
      last_c = cyc;
      expect_sym("post_rst_idle", 0, 0, 1'b1, 9216);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
